// File: rtl/traffic_request_conditioner.sv
// Conditions raw pedestrian buttons and siren detectors into clean controller requests.
// Optional stuck-button detection is built only when TRC_STUCK_BTN_EN is defined.
module traffic_request_conditioner #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned EMERG_HOLD      = 8,
  parameter int unsigned STUCK_CYCLES    = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_NS_raw,
  input  logic       btn_EW_raw,
  input  logic       siren_NS_raw,
  input  logic       siren_EW_raw,
  input  logic       pred_signal_NS,
  input  logic       pred_signal_EW,
  output logic       pred_NS,
  output logic       pred_EW,
  output logic       emergency_NS,
  output logic       emergency_EW,
  output logic       emerg_conflict,
  output logic [1:0] stuck_fault
);

  localparam int unsigned DbW   = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned HoldW = $clog2(EMERG_HOLD + 1);

  if (DEBOUNCE_CYCLES < 2 || EMERG_HOLD < 1 || STUCK_CYCLES < 1) begin : gen_param_check
    $error("traffic_request_conditioner: illegal parameter value");
  end

  typedef enum logic [2:0] {
    StIdle,
    StGntNs,
    StGntEw,
    StHoldNs,
    StHoldEw
  } emerg_state_e;

  // Bit order for all per-input vectors: [0]=btn NS, [1]=btn EW, [2]=siren NS, [3]=siren EW.
  logic [3:0]           w_raw;
  logic [3:0]           r_sync1;
  logic [3:0]           r_sync2;
  logic [3:0]           r_lvl;
  logic [3:0]           w_flip;
  logic [3:0][DbW-1:0]  r_db_cnt;

  logic [1:0]           w_ack;
  logic [1:0]           w_ped_rise;
  logic [1:0]           w_stuck_blk;
  logic [1:0]           r_pend;
  logic [1:0]           r_pred;
  logic                 w_any_grant;

  logic                 w_sns;
  logic                 w_sew;
  emerg_state_e         r_state;
  logic [HoldW-1:0]     r_hold_cnt;
  logic                 r_rr_ew;
  logic                 r_emerg_ns;
  logic                 r_emerg_ew;
  logic                 r_conflict;

  assign w_raw = {siren_EW_raw, siren_NS_raw, btn_EW_raw, btn_NS_raw};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
    end else begin
      r_sync1 <= w_raw;
      r_sync2 <= r_sync1;
    end
  end

  // A flip happens on the DEBOUNCE_CYCLES-th consecutive differing sample.
  always_comb begin
    w_flip = '0;
    for (int i = 0; i < 4; i++) begin
      w_flip[i] = (r_sync2[i] != r_lvl[i]) && (r_db_cnt[i] == DbW'(DEBOUNCE_CYCLES - 1));
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_lvl    <= '0;
      r_db_cnt <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (r_sync2[i] == r_lvl[i]) begin
          r_db_cnt[i] <= '0;
        end else if (w_flip[i]) begin
          r_lvl[i]    <= ~r_lvl[i];
          r_db_cnt[i] <= '0;
        end else begin
          r_db_cnt[i] <= r_db_cnt[i] + DbW'(1);
        end
      end
    end
  end

  assign w_ack       = {pred_signal_EW, pred_signal_NS};
  assign w_ped_rise  = w_flip[1:0] & ~r_lvl[1:0] & ~w_stuck_blk;
  assign w_any_grant = r_emerg_ns | r_emerg_ew;

  // Acknowledge wins over a coincident press; pending survives while masked by a grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pend <= '0;
      r_pred <= '0;
    end else begin
      r_pend <= (r_pend | w_ped_rise) & ~w_ack;
      r_pred <= r_pend & {2{~w_any_grant}};
    end
  end

  assign w_sns = r_lvl[2];
  assign w_sew = r_lvl[3];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= StIdle;
      r_hold_cnt <= '0;
      r_rr_ew    <= 1'b0;
      r_emerg_ns <= 1'b0;
      r_emerg_ew <= 1'b0;
    end else begin
      case (r_state)
        StIdle: begin
          if (w_sns && w_sew) begin
            r_rr_ew <= ~r_rr_ew;
            if (r_rr_ew) begin
              r_state    <= StGntEw;
              r_emerg_ew <= 1'b1;
            end else begin
              r_state    <= StGntNs;
              r_emerg_ns <= 1'b1;
            end
          end else if (w_sns) begin
            r_state    <= StGntNs;
            r_emerg_ns <= 1'b1;
          end else if (w_sew) begin
            r_state    <= StGntEw;
            r_emerg_ew <= 1'b1;
          end
        end
        StGntNs: begin
          if (!w_sns) begin
            r_state    <= StHoldNs;
            r_hold_cnt <= HoldW'(EMERG_HOLD - 1);
          end
        end
        StGntEw: begin
          if (!w_sew) begin
            r_state    <= StHoldEw;
            r_hold_cnt <= HoldW'(EMERG_HOLD - 1);
          end
        end
        StHoldNs: begin
          if (w_sns) begin
            r_state <= StGntNs;
          end else if (r_hold_cnt == '0) begin
            r_state    <= StIdle;
            r_emerg_ns <= 1'b0;
          end else begin
            r_hold_cnt <= r_hold_cnt - HoldW'(1);
          end
        end
        StHoldEw: begin
          if (w_sew) begin
            r_state <= StGntEw;
          end else if (r_hold_cnt == '0) begin
            r_state    <= StIdle;
            r_emerg_ew <= 1'b0;
          end else begin
            r_hold_cnt <= r_hold_cnt - HoldW'(1);
          end
        end
        default: begin
          r_state    <= StIdle;
          r_emerg_ns <= 1'b0;
          r_emerg_ew <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_conflict <= 1'b0;
    end else begin
      r_conflict <= w_sns & w_sew;
    end
  end

`ifdef TRC_STUCK_BTN_EN
  localparam int unsigned StW = $clog2(STUCK_CYCLES + 1);

  logic [1:0][StW-1:0] r_stk_cnt;
  logic [1:0][DbW-1:0] r_low_cnt;
  logic [1:0]          r_stuck;

  // Fault sets after STUCK_CYCLES high samples, clears after DEBOUNCE_CYCLES low samples.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stk_cnt <= '0;
      r_low_cnt <= '0;
      r_stuck   <= '0;
    end else begin
      for (int j = 0; j < 2; j++) begin
        if (r_lvl[j]) begin
          r_low_cnt[j] <= '0;
          if (r_stk_cnt[j] != StW'(STUCK_CYCLES)) begin
            r_stk_cnt[j] <= r_stk_cnt[j] + StW'(1);
          end
          if (r_stk_cnt[j] >= StW'(STUCK_CYCLES - 1)) begin
            r_stuck[j] <= 1'b1;
          end
        end else begin
          r_stk_cnt[j] <= '0;
          if (r_low_cnt[j] == DbW'(DEBOUNCE_CYCLES - 1)) begin
            r_stuck[j] <= 1'b0;
          end else begin
            r_low_cnt[j] <= r_low_cnt[j] + DbW'(1);
          end
        end
      end
    end
  end

  assign w_stuck_blk = r_stuck;
  assign stuck_fault = r_stuck;
`else
  assign w_stuck_blk = 2'b00;
  assign stuck_fault = 2'b00;
`endif

  assign pred_NS        = r_pred[0];
  assign pred_EW        = r_pred[1];
  assign emergency_NS   = r_emerg_ns;
  assign emergency_EW   = r_emerg_ew;
  assign emerg_conflict = r_conflict;

endmodule

// File: tb/tb_traffic_request_conditioner.sv
// Self-checking bench for traffic_request_conditioner against an edge-indexed history model.
module tb_traffic_request_conditioner;

  localparam int D    = 4;
  localparam int H    = 8;
  localparam int S    = 64;
  localparam int MAXE = 6000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_NS_raw = 1'b0;
  logic       btn_EW_raw = 1'b0;
  logic       siren_NS_raw = 1'b0;
  logic       siren_EW_raw = 1'b0;
  logic       pred_signal_NS = 1'b0;
  logic       pred_signal_EW = 1'b0;
  logic       pred_NS;
  logic       pred_EW;
  logic       emergency_NS;
  logic       emergency_EW;
  logic       emerg_conflict;
  logic [1:0] stuck_fault;

  traffic_request_conditioner #(
    .DEBOUNCE_CYCLES(D),
    .EMERG_HOLD     (H),
    .STUCK_CYCLES   (S)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .btn_NS_raw    (btn_NS_raw),
    .btn_EW_raw    (btn_EW_raw),
    .siren_NS_raw  (siren_NS_raw),
    .siren_EW_raw  (siren_EW_raw),
    .pred_signal_NS(pred_signal_NS),
    .pred_signal_EW(pred_signal_EW),
    .pred_NS       (pred_NS),
    .pred_EW       (pred_EW),
    .emergency_NS  (emergency_NS),
    .emergency_EW  (emergency_EW),
    .emerg_conflict(emerg_conflict),
    .stuck_fault   (stuck_fault)
  );

  always #5 clk = ~clk;

  // History of what was applied at each edge, and the debounced level after each edge.
  bit raw_h [4][MAXE];
  bit ack_h [2][MAXE];
  bit rst_h [MAXE];
  bit lvl_h [4][MAXE];
  int edge_n   = 0;
  int last_rst = 0;

  bit m_pend [2];
  bit m_pred [2];
  bit m_e    [2];
  bit m_fault[2];
  bit m_conf;
  int owner     = -1;
  bit rr_ew     = 1'b0;
  int last_high = 0;

  int n_checks = 0;
  int n_fail   = 0;

  // Value the debouncer sees at edge n: raw from two edges earlier, zero across reset.
  function automatic bit samp(int i, int n);
    if (n < 2) return 1'b0;
    if (rst_h[n-1] || rst_h[n-2]) return 1'b0;
    return raw_h[i][n-2];
  endfunction

  task automatic model_update(int n);
    bit p_pend[2];
    bit p_e[2];
    bit p_fault[2];
    bit s_ns, s_ew, s, rise, all_v, all_hi, all_lo, v;
    p_pend  = m_pend;
    p_e     = m_e;
    p_fault = m_fault;
    if (rst_h[n] || n == 0) begin
      for (int i = 0; i < 4; i++) lvl_h[i][n] = 1'b0;
      m_pend  = '{1'b0, 1'b0};
      m_pred  = '{1'b0, 1'b0};
      m_e     = '{1'b0, 1'b0};
      m_fault = '{1'b0, 1'b0};
      m_conf  = 1'b0;
      owner   = -1;
      rr_ew   = 1'b0;
      last_rst = n;
      return;
    end
    // Level becomes v once the last D post-reset samples all equal v.
    for (int i = 0; i < 4; i++) begin
      lvl_h[i][n] = lvl_h[i][n-1];
      if (n - D + 1 > last_rst) begin
        v = samp(i, n);
        all_v = 1'b1;
        for (int k = 0; k < D; k++) if (samp(i, n - k) != v) all_v = 1'b0;
        if (all_v) lvl_h[i][n] = v;
      end
    end
    for (int j = 0; j < 2; j++) begin
      rise = !lvl_h[j][n-1] && lvl_h[j][n];
      if (ack_h[j][n]) m_pend[j] = 1'b0;
      else if (rise && !p_fault[j]) m_pend[j] = 1'b1;
      m_pred[j] = p_pend[j] && !(p_e[0] || p_e[1]);
    end
    s_ns   = lvl_h[2][n-1];
    s_ew   = lvl_h[3][n-1];
    m_conf = s_ns && s_ew;
    // A grant lasts until EMERG_HOLD+1 edges pass without seeing its own siren.
    if (owner >= 0) begin
      s = (owner == 0) ? s_ns : s_ew;
      if (s) last_high = n;
      else if (n - last_high >= H + 1) owner = -1;
    end else if (s_ns && s_ew) begin
      owner = rr_ew ? 1 : 0;
      rr_ew = !rr_ew;
      last_high = n;
    end else if (s_ns) begin
      owner = 0;
      last_high = n;
    end else if (s_ew) begin
      owner = 1;
      last_high = n;
    end
    m_e[0] = (owner == 0);
    m_e[1] = (owner == 1);
`ifdef TRC_STUCK_BTN_EN
    for (int j = 0; j < 2; j++) begin
      all_hi = (n - S >= 0);
      for (int t = n - S; t < n; t++) if (t < 0 || !lvl_h[j][t]) all_hi = 1'b0;
      all_lo = 1'b1;
      for (int t = n - D; t < n; t++) if (t >= 0 && lvl_h[j][t]) all_lo = 1'b0;
      if (all_hi) m_fault[j] = 1'b1;
      else if (all_lo) m_fault[j] = 1'b0;
    end
`else
    all_hi = 1'b0;
    all_lo = 1'b0;
    m_fault = '{1'b0, 1'b0};
`endif
  endtask

  task automatic step();
    @(posedge clk);
    if (edge_n >= MAXE) begin
      $display("FAIL edge_budget: got %0d edges, limit %0d", edge_n, MAXE);
      $fatal(1, "edge budget exhausted");
    end
    raw_h[0][edge_n] = btn_NS_raw;
    raw_h[1][edge_n] = btn_EW_raw;
    raw_h[2][edge_n] = siren_NS_raw;
    raw_h[3][edge_n] = siren_EW_raw;
    ack_h[0][edge_n] = pred_signal_NS;
    ack_h[1][edge_n] = pred_signal_EW;
    rst_h[edge_n]    = reset;
    model_update(edge_n);
    edge_n++;
    #1;
  endtask

  task automatic drive_idle();
    btn_NS_raw = 0; btn_EW_raw = 0; siren_NS_raw = 0; siren_EW_raw = 0;
    pred_signal_NS = 0; pred_signal_EW = 0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    btn_NS_raw = 1; btn_EW_raw = 1; siren_NS_raw = 1; siren_EW_raw = 1;
    for (int c = 0; c < 3; c++) begin
      step();
      n_checks++;
      if ({pred_NS, pred_EW, emergency_NS, emergency_EW, emerg_conflict, stuck_fault} !== 7'd0) begin
        n_fail++;
        $display("FAIL reset_outputs: got %b required 0000000",
                 {pred_NS, pred_EW, emergency_NS, emergency_EW, emerg_conflict, stuck_fault});
      end
    end
    drive_idle();
    reset = 1'b0;
    for (int c = 0; c < 6; c++) begin
      step();
      n_checks++;
      if ({emergency_NS, emergency_EW, emerg_conflict} !== {m_e[0], m_e[1], m_conf}) begin
        n_fail++;
        $display("FAIL post_reset_emerg: got %b%b%b required %b%b%b", emergency_NS,
                 emergency_EW, emerg_conflict, m_e[0], m_e[1], m_conf);
      end
    end
  endtask

  task automatic test_ped_press();
    int cap;
    int first_pred = -1;
    int hold = 10 + $urandom_range(0, 4);
    btn_NS_raw = 1;
    cap = edge_n;
    for (int c = 0; c < hold; c++) begin
      step();
      n_checks++;
      if (pred_NS !== m_pred[0]) begin
        n_fail++;
        $display("FAIL press_pred_ns edge %0d: got %b required %b", edge_n - 1, pred_NS, m_pred[0]);
      end
      if (pred_NS === 1'b1 && first_pred < 0) first_pred = edge_n - 1;
    end
    n_checks++;
    if (first_pred - cap != D + 2) begin
      n_fail++;
      $display("FAIL press_latency: got %0d edges required %0d", first_pred - cap, D + 2);
    end
    pred_signal_NS = 1;
    step();
    pred_signal_NS = 0;
    for (int c = 0; c < 8; c++) begin
      step();
      n_checks++;
      if (pred_NS !== 1'b0 || m_pred[0] !== 1'b0) begin
        n_fail++;
        $display("FAIL ack_clear_held edge %0d: got %b model %b required 0", edge_n - 1, pred_NS,
                 m_pred[0]);
      end
    end
    btn_NS_raw = 0;
    for (int c = 0; c < 10; c++) begin
      step();
      n_checks++;
      if (pred_NS !== m_pred[0]) begin
        n_fail++;
        $display("FAIL release_pred_ns: got %b required %b", pred_NS, m_pred[0]);
      end
    end
  endtask

  task automatic test_glitch();
    int len;
    for (int r = 0; r < 6; r++) begin
      len = $urandom_range(1, D - 1);
      btn_EW_raw = 1;
      for (int c = 0; c < len; c++) step();
      btn_EW_raw = 0;
      for (int c = 0; c < 8; c++) begin
        step();
        n_checks++;
        if (pred_EW !== 1'b0 || pred_EW !== m_pred[1]) begin
          n_fail++;
          $display("FAIL glitch_len%0d_pred_ew: got %b model %b required 0", len, pred_EW,
                   m_pred[1]);
        end
      end
    end
  endtask

  task automatic test_emerg_mask();
    int ew_cycles = 0;
    btn_NS_raw = 1;
    for (int c = 0; c < 8; c++) step();
    btn_NS_raw = 0;
    for (int c = 0; c < 5; c++) step();
    siren_EW_raw = 1;
    for (int c = 0; c < 40; c++) begin
      if (c == 20) siren_EW_raw = 0;
      step();
      if (emergency_EW === 1'b1) ew_cycles++;
      n_checks++;
      if ({emergency_NS, emergency_EW, pred_NS} !== {m_e[0], m_e[1], m_pred[0]}) begin
        n_fail++;
        $display("FAIL mask_grant edge %0d: got eNS/eEW/pNS %b%b%b required %b%b%b", edge_n - 1,
                 emergency_NS, emergency_EW, pred_NS, m_e[0], m_e[1], m_pred[0]);
      end
    end
    n_checks++;
    if (ew_cycles != 20 + H) begin
      n_fail++;
      $display("FAIL hold_length: got %0d grant cycles required %0d", ew_cycles, 20 + H);
    end
    n_checks++;
    if (pred_NS !== 1'b1) begin
      n_fail++;
      $display("FAIL unmask_pred_ns: got %b required 1", pred_NS);
    end
    pred_signal_NS = 1;
    step();
    pred_signal_NS = 0;
    for (int c = 0; c < 3; c++) step();
  endtask

  task automatic test_conflict_rr();
    int first_dir, first_end, second_start;
    reset = 1;
    drive_idle();
    step();
    step();
    reset = 0;
    for (int r = 0; r < 2; r++) begin
      first_dir = -1; first_end = -1; second_start = -1;
      siren_NS_raw = 1;
      siren_EW_raw = 1;
      for (int c = 0; c < 60; c++) begin
        if (c == 12) begin
          if (r == 0) siren_NS_raw = 0;
          else siren_EW_raw = 0;
        end
        if (c == 40) begin
          siren_NS_raw = 0;
          siren_EW_raw = 0;
        end
        step();
        n_checks++;
        if ({emergency_NS, emergency_EW, emerg_conflict} !== {m_e[0], m_e[1], m_conf} ||
            (emergency_NS && emergency_EW)) begin
          n_fail++;
          $display("FAIL rr%0d_grant edge %0d: got eNS/eEW/conf %b%b%b required %b%b%b", r,
                   edge_n - 1, emergency_NS, emergency_EW, emerg_conflict, m_e[0], m_e[1],
                   m_conf);
        end
        if (first_dir < 0 && (emergency_NS || emergency_EW)) first_dir = emergency_NS ? 0 : 1;
        else if (first_dir >= 0 && first_end < 0 &&
                 !((first_dir == 0) ? emergency_NS : emergency_EW)) first_end = edge_n - 1;
        else if (first_end >= 0 && second_start < 0 &&
                 ((first_dir == 0) ? emergency_EW : emergency_NS)) second_start = edge_n - 1;
      end
      n_checks++;
      if (first_dir != r) begin
        n_fail++;
        $display("FAIL rr%0d_first_dir: got %0d required %0d", r, first_dir, r);
      end
      n_checks++;
      if (second_start - first_end != 1) begin
        n_fail++;
        $display("FAIL rr%0d_idle_gap: got %0d required 1", r, second_start - first_end);
      end
    end
  endtask

  task automatic test_reset_mid_grant();
    siren_NS_raw = 1;
    for (int c = 0; c < 10; c++) step();
    n_checks++;
    if (emergency_NS !== 1'b1) begin
      n_fail++;
      $display("FAIL midgrant_setup: got %b required 1", emergency_NS);
    end
    reset = 1;
    step();
    reset = 0;
    n_checks++;
    if ({pred_NS, pred_EW, emergency_NS, emergency_EW, emerg_conflict, stuck_fault} !== 7'd0) begin
      n_fail++;
      $display("FAIL midgrant_reset: got %b required 0000000",
               {pred_NS, pred_EW, emergency_NS, emergency_EW, emerg_conflict, stuck_fault});
    end
    for (int c = 0; c < 40; c++) begin
      if (c == 15) siren_NS_raw = 0;
      step();
      n_checks++;
      if ({emergency_NS, emergency_EW} !== {m_e[0], m_e[1]}) begin
        n_fail++;
        $display("FAIL midgrant_restart edge %0d: got %b%b required %b%b", edge_n - 1,
                 emergency_NS, emergency_EW, m_e[0], m_e[1]);
      end
    end
  endtask

  task automatic test_stuck();
    btn_NS_raw = 1;
    for (int c = 0; c < 100; c++) begin
      if (c == 80) btn_NS_raw = 0;
      step();
      n_checks++;
      if (stuck_fault !== {m_fault[1], m_fault[0]} || pred_NS !== m_pred[0]) begin
        n_fail++;
        $display("FAIL stuck edge %0d: got fault %b pred %b required %b%b %b", edge_n - 1,
                 stuck_fault, pred_NS, m_fault[1], m_fault[0], m_pred[0]);
      end
    end
    pred_signal_NS = 1;
    step();
    pred_signal_NS = 0;
  endtask

  task automatic test_random();
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 11) == 0) btn_NS_raw = ~btn_NS_raw;
      if ($urandom_range(0, 11) == 0) btn_EW_raw = ~btn_EW_raw;
      if ($urandom_range(0, 15) == 0) siren_NS_raw = ~siren_NS_raw;
      if ($urandom_range(0, 15) == 0) siren_EW_raw = ~siren_EW_raw;
      pred_signal_NS = ($urandom_range(0, 7) == 0);
      pred_signal_EW = ($urandom_range(0, 7) == 0);
      reset = ($urandom_range(0, 249) == 0);
      step();
      n_checks++;
      if ({pred_NS, pred_EW} !== {m_pred[0], m_pred[1]}) begin
        n_fail++;
        $display("FAIL rand_pred edge %0d: got %b%b required %b%b", edge_n - 1, pred_NS, pred_EW,
                 m_pred[0], m_pred[1]);
      end
      n_checks++;
      if ({emergency_NS, emergency_EW} !== {m_e[0], m_e[1]} || (emergency_NS && emergency_EW))
      begin
        n_fail++;
        $display("FAIL rand_emerg edge %0d: got %b%b required %b%b", edge_n - 1, emergency_NS,
                 emergency_EW, m_e[0], m_e[1]);
      end
      n_checks++;
      if (emerg_conflict !== m_conf) begin
        n_fail++;
        $display("FAIL rand_conflict edge %0d: got %b required %b", edge_n - 1, emerg_conflict,
                 m_conf);
      end
      n_checks++;
      if (stuck_fault !== {m_fault[1], m_fault[0]}) begin
        n_fail++;
        $display("FAIL rand_stuck edge %0d: got %b required %b%b", edge_n - 1, stuck_fault,
                 m_fault[1], m_fault[0]);
      end
    end
    reset = 0;
    drive_idle();
  endtask

  initial begin
    test_reset();
    test_ped_press();
    test_glitch();
    test_emerg_mask();
    test_conflict_rr();
    test_reset_mid_grant();
    test_stuck();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
